// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary datapath: trit codes, the packer FSM
// state type and a small helper for advancing a power-of-three weight.
// Imported by trit_weight_mul and trit_pack5_serial.
package ternary_pkg;

    // Two-bit trit encoding; 2'b11 is not a trit and is flagged by users.
    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0   = 2'b00;
    localparam trit_t TRIT_1   = 2'b01;
    localparam trit_t TRIT_2   = 2'b10;
    localparam trit_t TRIT_BAD = 2'b11;

    // 3^5 - 1 = 242 is the largest value that fits a byte.
    localparam int PACK_N_MAX = 5;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_e;

    // Next power of three. The result is only used while more trits are
    // still expected, so it never exceeds 81 and the 7-bit truncation is safe.
    function automatic logic [6:0] weight_times3(input logic [6:0] w);
        logic [7:0] t;
        t = {w, 1'b0} + {1'b0, w};
        return t[6:0];
    endfunction

endpackage

// File: rtl/trit_weight_mul.sv
// Purpose : multiply one trit by a power-of-three weight (0, w or 2w).
// Ports   : trit_i (trit code), weight_i (7-bit weight), prod_o (8-bit product).
//           Purely combinational; the illegal code contributes zero.
module trit_weight_mul
    import ternary_pkg::*;
(
    input  trit_t      trit_i,
    input  logic [6:0] weight_i,
    output logic [7:0] prod_o
);

    always_comb begin
        prod_o = 8'd0;
        case (trit_i)
            TRIT_1:  prod_o = {1'b0, weight_i};
            TRIT_2:  prod_o = {weight_i, 1'b0};
            default: prod_o = 8'd0;
        endcase
    end

endmodule

// File: rtl/trit_pack5_serial.sv
// Purpose : serial ternary packer; N trits (first = least significant) become
//           one byte b = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4. in_last closes a
//           partial byte early. err is sticky for any accepted code 2'b11.
// Ports   : clk/rst (sync, active-high); in_valid/in_trit/in_last/in_ready
//           trit input handshake; out_valid/out_byte/out_last/out_ready byte
//           output handshake; err sticky illegal-code flag.
// Timing  : out_valid rises the cycle after the closing trit; one byte per
//           N+1 cycles at full rate. in_ready is a pure state decode.
module trit_pack5_serial
    import ternary_pkg::*;
#(
    parameter int N = 5   // trits per byte, legal 1..PACK_N_MAX
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_trit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err
);

    localparam logic [2:0] CNT_LAST = 3'(N - 1);

    pack_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [6:0]  weight_q, weight_d;
    logic [7:0]  obyte_q, obyte_d;
    logic        olast_q, olast_d;
    logic        ovld_q, ovld_d;
    logic        err_q, err_d;

    logic [7:0]  prod;
    logic [7:0]  sum;

    trit_weight_mul u_mul (
        .trit_i   (in_trit),
        .weight_i (weight_q),
        .prod_o   (prod)
    );

    // Running value including the trit currently offered; it is the final
    // byte when this trit closes the group.
    assign sum = acc_q + prod;

    // No dependence on out_ready: upstream sees only registered state.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = ovld_q;
    assign out_byte  = obyte_q;
    assign out_last  = olast_q;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        weight_d = weight_q;
        obyte_d  = obyte_q;
        olast_d  = olast_q;
        ovld_d   = ovld_q;
        err_d    = err_q;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (in_trit == TRIT_BAD) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == CNT_LAST || in_last) begin
                        obyte_d  = sum;
                        olast_d  = in_last;
                        ovld_d   = 1'b1;
                        acc_d    = 8'd0;
                        weight_d = 7'd1;
                        cnt_d    = 3'd0;
                        state_d  = HOLD;
                    end else begin
                        acc_d    = sum;
                        weight_d = weight_times3(weight_q);
                        cnt_d    = cnt_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            cnt_q    <= 3'd0;
            acc_q    <= 8'd0;
            weight_q <= 7'd1;
            obyte_q  <= 8'd0;
            olast_q  <= 1'b0;
            ovld_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            weight_q <= weight_d;
            obyte_q  <= obyte_d;
            olast_q  <= olast_d;
            ovld_q   <= ovld_d;
            err_q    <= err_d;
        end
    end

endmodule
